// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the divider rate controller.
// Holds the FSM state encoding, mode encodings and the zero-to-one normaliser.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2
   } state_t;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   // Wide enough for any divisor/burst width used here; callers cast in and out.
   localparam int NORM_W = 64;

   function automatic logic [NORM_W-1:0] norm_nonzero(input logic [NORM_W-1:0] v);
      return (v == '0) ? {{(NORM_W-1){1'b0}}, 1'b1} : v;
   endfunction

endpackage

// File: rtl/div_counter.sv
// Divide counter: counts 0..div-1 while enabled, wraps at terminal count.
// The terminal flag is combinational so the controller can register tick from it.
module div_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] div,
   output logic [CNT_W-1:0] cnt,
   output logic             terminal
);

   assign terminal = (cnt == div - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= terminal ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/div_rate_ctrl.sv
// Clock-divider rate controller: active/pending divisor, run/burst FSM, tick and clk_div.
// Optional status outputs (tick_cnt, cur_div) are built when DIV_RATE_CTRL_STATUS_EN is defined.
module div_rate_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int BURST_W     = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_div,
   input  logic               mode,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               start,
   input  logic               stop,
   output logic               tick,
   output logic               clk_div,
   output logic               busy,
   output logic               done,
`ifdef DIV_RATE_CTRL_STATUS_EN
   output logic [31:0]        tick_cnt,
   output logic [CNT_W-1:0]   cur_div,
`endif
   output state_t             fsm_state
);

   // cfg handshake: a transfer happens on any cycle where cfg_valid && cfg_ready.
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     active_div;
   logic [CNT_W-1:0]     pend_div;
   logic                 pend_vld;
   logic                 stop_req;
   logic [BURST_W-1:0]   burst_rem;
   logic [CNT_W-1:0]     cnt;
   logic                 terminal;
   logic                 start_go;
   logic                 end_now;
   logic                 count_en;
   logic                 period_end;
   logic                 cfg_fire;
   logic [CNT_W-1:0]     cfg_norm;

   assign busy       = (state_q != IDLE);
   assign fsm_state  = state_q;
   assign cfg_ready  = !pend_vld;
   assign cfg_fire   = cfg_valid && cfg_ready;
   assign cfg_norm   = CNT_W'(norm_nonzero(NORM_W'(cfg_div)));
   assign count_en   = busy || start_go;
   assign period_end = busy && terminal;

   div_counter #(
      .CNT_W(CNT_W)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .en       (count_en),
      .clr      (!count_en),
      .div      (active_div),
      .cnt      (cnt),
      .terminal (terminal)
   );

   always_comb begin
      state_d  = state_q;
      start_go = 1'b0;
      end_now  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               start_go = 1'b1;
               state_d  = (mode == MODE_BURST) ? BURST : RUN;
            end
         end
         RUN: begin
            if (terminal && stop_req) begin
               end_now = 1'b1;
               state_d = IDLE;
            end
         end
         BURST: begin
            if (terminal && (stop_req || burst_rem == BURST_W'(1))) begin
               end_now = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The counter already sits at 0 in the start cycle, so the first tick lands active_div cycles later.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= 1'b0;
         clk_div <= 1'b0;
         done    <= 1'b0;
      end else begin
         tick <= count_en && terminal;
         done <= end_now;
         if (count_en && terminal) begin
            clk_div <= ~clk_div;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stop_req  <= 1'b0;
         burst_rem <= '0;
      end else begin
         if (!busy || end_now) begin
            stop_req <= 1'b0;
         end else if (stop) begin
            stop_req <= 1'b1;
         end
         if (start_go) begin
            burst_rem <= BURST_W'(norm_nonzero(NORM_W'(burst_len)));
         end else if (period_end && state_q == BURST) begin
            burst_rem <= burst_rem - BURST_W'(1);
         end
      end
   end

   // Divisor changes while busy wait in pend_div and only land on a period boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_div <= CNT_W'(DEFAULT_DIV);
         pend_div   <= '0;
         pend_vld   <= 1'b0;
      end else if (!busy) begin
         if (pend_vld) begin
            active_div <= pend_div;
            pend_vld   <= 1'b0;
         end else if (cfg_fire) begin
            active_div <= cfg_norm;
         end
      end else begin
         if (period_end && pend_vld) begin
            active_div <= pend_div;
            pend_vld   <= 1'b0;
         end
         if (cfg_fire) begin
            pend_div <= cfg_norm;
            pend_vld <= 1'b1;
         end
      end
   end

`ifdef DIV_RATE_CTRL_STATUS_EN
   assign cur_div = active_div;

   always_ff @(posedge clk) begin
      if (rst || start_go) begin
         tick_cnt <= '0;
      end else if (tick && tick_cnt != 32'hFFFF_FFFF) begin
         tick_cnt <= tick_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_div_rate_ctrl.sv
// Bench for div_rate_ctrl: directed scenarios push expected ticks into a queue,
// a negedge monitor pops and compares each tick (cycle, clk_div level, done).
module tb_div_rate_ctrl;
   import div_ctrl_pkg::*;

   localparam int CNT_W   = 32;
   localparam int BURST_W = 16;
   localparam int EW      = 18;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [CNT_W-1:0]   cfg_div;
   logic               mode;
   logic [BURST_W-1:0] burst_len;
   logic               start;
   logic               stop;
   logic               tick;
   logic               clk_div;
   logic               busy;
   logic               done;
   state_t             fsm_state;
`ifdef DIV_RATE_CTRL_STATUS_EN
   logic [31:0]        tick_cnt;
   logic [CNT_W-1:0]   cur_div;
`endif

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        exp_clk;
   logic [EW-1:0] exp_q[$];

   div_rate_ctrl #(
      .CNT_W(CNT_W),
      .BURST_W(BURST_W),
      .DEFAULT_DIV(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .mode      (mode),
      .burst_len (burst_len),
      .start     (start),
      .stop      (stop),
      .tick      (tick),
      .clk_div   (clk_div),
      .busy      (busy),
      .done      (done),
`ifdef DIV_RATE_CTRL_STATUS_EN
      .tick_cnt  (tick_cnt),
      .cur_div   (cur_div),
`endif
      .fsm_state (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] e;
      got = {cyc[15:0], clk_div, done};
      if (tick) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_tick cyc=%0d clk_div=%0b done=%0b", cyc, clk_div, done);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL tick_event got cyc=%0d clk_div=%0b done=%0b want cyc=%0d clk_div=%0b done=%0b",
                        got[17:2], got[1], got[0], e[17:2], e[1], e[0]);
            end
         end
      end else if (done) begin
         total++;
         bad++;
         $display("FAIL done_without_tick cyc=%0d", cyc);
      end
   end

   // driver tasks
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, want, cyc);
      end
   endtask

   task automatic push_tick(input int unsigned c, input logic last);
      logic [15:0] cc;
      cc = c[15:0];
      exp_clk = ~exp_clk;
      exp_q.push_back({cc, exp_clk, last});
   endtask

   task automatic drain(input string name, input int limit);
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < limit) begin
         step(1);
         waited++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic cfg_idle(input logic [CNT_W-1:0] d);
      cfg_valid = 1'b1;
      cfg_div   = d;
      check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
      step(1);
      cfg_valid = 1'b0;
   endtask

   task automatic idle_checks(input string name);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_state"}, 32'(fsm_state), 32'(IDLE));
   endtask

   initial begin
      int unsigned s;
      rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; mode = MODE_CONT;
      burst_len = '0; start = 1'b0; stop = 1'b0;
      exp_clk = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);

      // reset state
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_clk_div", 32'(clk_div), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      idle_checks("rst");

      // div 4 continuous, switch to div 2 mid-period, then stop
      cfg_idle(32'd4);
      s = cyc;
      push_tick(s + 4, 1'b0);  push_tick(s + 8, 1'b0);  push_tick(s + 12, 1'b0);
      push_tick(s + 16, 1'b0); push_tick(s + 18, 1'b0); push_tick(s + 20, 1'b0);
      push_tick(s + 22, 1'b1);
      mode = MODE_CONT; start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      cfg_valid = 1'b1; cfg_div = 32'd2;
      check("cfg_ready_run", 32'(cfg_ready), 32'd1);
      step(1);
      cfg_valid = 1'b0;
      check("pend_ready_lo1", 32'(cfg_ready), 32'd0);
      check("run_busy", 32'(busy), 32'd1);
      check("run_state", 32'(fsm_state), 32'(RUN));
      step(1);
      check("pend_ready_lo2", 32'(cfg_ready), 32'd0);
      step(1);
      check("pend_ready_hi", 32'(cfg_ready), 32'd1);
      step(4);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      drain("drain_cont", 40);
      idle_checks("cont_end");
      check("clk_div_hold", 32'(clk_div), 32'(exp_clk));

      // burst of 3 at div 5
      cfg_idle(32'd5);
      s = cyc;
      push_tick(s + 5, 1'b0); push_tick(s + 10, 1'b0); push_tick(s + 15, 1'b1);
      mode = MODE_BURST; burst_len = 16'd3; start = 1'b1;
      step(1);
      start = 1'b0;
      check("burst_state", 32'(fsm_state), 32'(BURST));
      drain("drain_burst", 40);
      idle_checks("burst_end");
      step(15);
      idle_checks("burst_quiet");

      // stop one cycle after a tick at div 6
      cfg_idle(32'd6);
      s = cyc;
      push_tick(s + 6, 1'b0); push_tick(s + 12, 1'b0); push_tick(s + 18, 1'b1);
      mode = MODE_CONT; start = 1'b1;
      step(1);
      start = 1'b0;
      step(12);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      drain("drain_stop", 40);
      step(15);
      idle_checks("stop_quiet");

      // divisor 0 behaves as 1
      cfg_idle(32'd0);
      s = cyc;
      for (int i = 1; i <= 6; i++) push_tick(s + i, (i == 6));
      mode = MODE_CONT; start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      drain("drain_div1", 20);

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0;
      check("startstop_busy", 32'(busy), 32'd0);
      step(6);
      idle_checks("startstop");

      // reset mid-burst with a pending divisor
      cfg_idle(32'd3);
      s = cyc;
      push_tick(s + 3, 1'b0); push_tick(s + 6, 1'b0);
      mode = MODE_BURST; burst_len = 16'd10; start = 1'b1;
      step(1);
      start = 1'b0;
      step(6);
      cfg_valid = 1'b1; cfg_div = 32'd7;
      step(1);
      cfg_valid = 1'b0;
      check("midburst_pend", 32'(cfg_ready), 32'd0);
      rst = 1'b1;
      exp_clk = 1'b0;
      step(1);
      rst = 1'b0;
      check("rst2_tick", 32'(tick), 32'd0);
      check("rst2_clk_div", 32'(clk_div), 32'd0);
      check("rst2_done", 32'(done), 32'd0);
      check("rst2_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst2_queue", 32'(exp_q.size()), 32'd0);
      idle_checks("rst2");

      // after reset the default divisor (2) is active again
      s = cyc;
      push_tick(s + 2, 1'b0); push_tick(s + 4, 1'b0); push_tick(s + 6, 1'b1);
      mode = MODE_CONT; start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      drain("drain_default", 20);
      step(5);
      idle_checks("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
